// File: rtl/cpu_run_sched.sv
// Run/step sequencer: debounces the STEP/MODE keys and issues one-cycle start pulses to cpu_mem.
// Define CPU_RUN_BREAKPOINT_EN to stop RUN at a breakpoint address.

module cpu_run_sched #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned RUN_DIV    = 5000000,
  parameter logic [3:0]  HALT_OP    = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  key,
  input  logic [7:0]  pc,
  input  logic [15:0] ir,
  input  logic [7:0]  bp_addr,
  input  logic        bp_valid,
  output logic        start,
  output logic [1:0]  mode,
  output logic [15:0] step_cnt
);

  localparam int unsigned DebW  = $clog2(DEB_CYCLES);
  localparam int unsigned TickW = $clog2(RUN_DIV);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYCLES - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    StStep = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } state_e;

  logic [1:0]      sync1_q, sync2_q, deb_q, ev_q;
  logic [DebW-1:0] deb_cnt_q [2];

  state_e           state_q;
  logic             start_q;
  logic [15:0]      step_cnt_q;
  logic [TickW-1:0] tick_q;
  logic             tick_hit_q;
  logic             is_halt;

  assign is_halt = (ir[15:12] == HALT_OP);

  // Keys idle high; reset to the released level so no press is seen out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
      ev_q    <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      ev_q    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DebLast) begin
          deb_cnt_q[i] <= '0;
          deb_q[i]     <= sync2_q[i];
          ev_q[i]      <= ~sync2_q[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DebW'(1);
        end
      end
    end
  end

`ifdef CPU_RUN_BREAKPOINT_EN
  logic bp_armed_q;
  logic unused_ir;
  assign unused_ir = ^ir[11:0];
`else
  logic unused_in;
  assign unused_in = ^{ir[11:0], pc, bp_addr, bp_valid};
`endif

  // tick_hit_q delays the RUN decision one cycle after the counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StStep;
      start_q    <= 1'b0;
      step_cnt_q <= '0;
      tick_q     <= '0;
      tick_hit_q <= 1'b0;
`ifdef CPU_RUN_BREAKPOINT_EN
      bp_armed_q <= 1'b1;
`endif
    end else begin
      start_q    <= 1'b0;
      tick_q     <= '0;
      tick_hit_q <= 1'b0;
`ifdef CPU_RUN_BREAKPOINT_EN
      if (pc != bp_addr) bp_armed_q <= 1'b1;
`endif
      case (state_q)
        StStep: begin
          if (ev_q[1]) begin
            state_q <= StRun;
          end else if (ev_q[0]) begin
            if (is_halt) begin
              state_q <= StHalt;
            end else begin
              start_q    <= 1'b1;
              step_cnt_q <= step_cnt_q + 16'd1;
            end
          end
        end
        StRun: begin
          if (ev_q[1]) begin
            state_q <= StStep;
          end else begin
            tick_q     <= (tick_q == TickLast) ? '0 : tick_q + TickW'(1);
            tick_hit_q <= (tick_q == TickLast);
            if (tick_hit_q) begin
              if (is_halt) begin
                state_q <= StHalt;
              end
`ifdef CPU_RUN_BREAKPOINT_EN
              else if (bp_valid && (pc == bp_addr) && bp_armed_q) begin
                state_q    <= StStep;
                bp_armed_q <= 1'b0;
              end
`endif
              else begin
                start_q    <= 1'b1;
                step_cnt_q <= step_cnt_q + 16'd1;
              end
            end
          end
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StStep;
      endcase
    end
  end

  assign start    = start_q;
  assign mode     = state_q;
  assign step_cnt = step_cnt_q;

endmodule

// File: doc/cpu_run_sched.md
# cpu_run_sched

Run/step sequencer for the simple processor. It debounces the two board keys and decides when to issue the one-cycle `start` pulse that advances `cpu_mem` by one instruction. It supports single-step, free-run at a fixed rate, and automatic halt on a HALT opcode. It sits between the board keys and `cpu_mem` at the top level, beside the display/step logic.

## Interface
- `DEB_CYCLES`, default 500000: consecutive stable cycles needed before a key level is accepted (10 ms at 50 MHz); must be ≥ 2.
- `RUN_DIV`, default 5000000: cycles between `start` pulses in RUN; must be ≥ 4.
- `HALT_OP`, default 4'hF: opcode in `ir[15:12]` that halts the sequencer.
- `clk` input 1: single system clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `key` input 2: raw pushbuttons, active-low. `key[0]` = STEP, `key[1]` = MODE.
- `pc` input 8: current program counter from `cpu_mem`.
- `ir` input 16: current instruction register from `cpu_mem`.
- `bp_addr` input 8: breakpoint address; used only with the breakpoint macro.
- `bp_valid` input 1: breakpoint enable; used only with the breakpoint macro.
- `start` output 1: one-cycle pulse; `cpu_mem` executes one instruction.
- `mode` output 2: 2'b00 STEP, 2'b01 RUN, 2'b10 HALT.
- `step_cnt` output 16: number of `start` pulses issued since reset.

## Operation
- **Key path (per key):**
  - 2-FF synchronizer.
  - Debounced level `deb`; reset value 1 (released).
  - Counter counts consecutive cycles where the synced level differs from `deb` and clears whenever they match. When the mismatch has lasted `DEB_CYCLES` cycles, `deb` takes the synced level.
  - A 1→0 transition of `deb` produces a registered one-cycle press event (`ev0` / `ev1`). Release produces no event.
- **FSM states:** STEP (reset state), RUN, HALT.
- **STEP:**
  - `ev1` → RUN.
  - `ev0` with `ir[15:12] == HALT_OP` → HALT; no `start`.
  - `ev0` otherwise → `start` pulse next cycle; stay in STEP.
- **RUN:**
  - `ev0` is ignored.
  - `ev1` → STEP.
  - Tick counter runs 0..`RUN_DIV`-1 and is cleared on entering RUN. At count `RUN_DIV`-1:
    - `ir[15:12] == HALT_OP` → HALT, no `start`.
    - Otherwise → `start` pulse next cycle.
- **HALT:** all key events are ignored. Only `rst` exits HALT.
- **Simultaneous events:** `ev0` and `ev1` in the same cycle → `ev1` wins, `ev0` dropped. `ev1` coinciding with a RUN tick → go to STEP, no `start` for that tick.
- **step_cnt:** increments by 1 in the same cycle `start` is high. Wraps 16'hFFFF → 16'h0000.
- **Reset:** clears FSM to STEP, tick counter, debounce counters, events and `step_cnt`. `rst` asserted mid-debounce or mid-RUN discards all pending state; no `start` is issued in the reset cycle or the cycle after it.

## Timing
- **Reset values:** `start` = 0, `mode` = 2'b00, `step_cnt` = 0.
- **`start`** is registered, exactly one cycle wide, and never high on two consecutive cycles.
- **Key-to-start latency (STEP mode):** raw `key[0]` falls and stays low → `start` is high exactly `DEB_CYCLES`+3 cycles later (2 synchronizer + debounce + event register + start register, the edge of the fall counted as cycle 0).
- **RUN rate:** first `start` comes `RUN_DIV`+1 cycles after the `mode` = RUN edge; then one `start` every `RUN_DIV` cycles.
- **`mode`** updates on the clock edge after the deciding event.
- A key bounce shorter than `DEB_CYCLES` cycles produces no event.

## Configuration
- **`CPU_RUN_BREAKPOINT_EN` defined:**
  - In RUN, at a tick with `bp_valid` = 1, `pc == bp_addr` and the breakpoint armed → go to STEP, no `start`, breakpoint disarmed.
  - The breakpoint re-arms on the first cycle `pc != bp_addr`, so an `ev0` step off the breakpoint works normally.
  - HALT_OP check has priority over the breakpoint.
  - The armed flag resets to 1.
- **Not defined:** `bp_addr` and `bp_valid` are ignored and no breakpoint logic is synthesized. The ports remain present.

## Test plan
Bench parameters: `DEB_CYCLES` = 4, `RUN_DIV` = 8.
- **Single step:** `ir` = 16'h1234, `key[0]` low for 20 cycles → exactly one `start`, 7 cycles after the fall; `step_cnt` = 1; `mode` = 00.
- **Bounce rejection:** `key[0]` low 3 cycles, high 3, low 3, then high → no `start`, `step_cnt` = 0.
- **Run mode:** press `key[1]` → `mode` = 01. `start` every 8 cycles, with the first 9 cycles after the `mode` change. Second `key[1]` press → `mode` = 00 and no further `start`.
- **Halt:** in RUN, set `ir` = 16'hF000 → at the next tick `mode` = 10 and no `start`. Presses on both keys are then ignored; `rst` → `mode` = 00, `step_cnt` = 0.
- **Wrap and priority:** force 65536 steps → `step_cnt` returns to 0. Assert `key[0]` and `key[1]` together → `mode` = 01 and no `start` from `key[0]`.
- **Breakpoint (macro on):** `bp_valid` = 1, `bp_addr` = 8'h05, RUN while `pc` increments. At the tick with `pc` = 8'h05 → `mode` = 00, no `start`. Then `ev0` → one `start`.
